// File: rtl/choose_cursor_ctrl.sv
// Character-select sequencer: key pulses move a registered cursor over a 2 x NUM_COLS grid,
// blink the selection frame while browsing, then lock, confirm and offer the chosen id.
module choose_cursor_ctrl #(
  parameter int NUM_COLS       = 4,
  parameter int INIT_ID        = 1,
  parameter int BLINK_FRAMES   = 15,
  parameter int CONFIRM_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_enter,
  input  logic       key_back,
  input  logic       sel_ready,
  output logic [7:0] pokemon_id,
  output logic       frame_en,
  output logic       sel_valid,
  output logic [7:0] sel_id,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BROWSE = 3'd1,
    S_LOCKED = 3'd2,
    S_OFFER  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] NC         = 8'(NUM_COLS);
  localparam logic [7:0] INIT8      = 8'(INIT_ID);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] CONF_LAST  = 8'(CONFIRM_FRAMES - 1);

  state_t     r_state;
  logic [7:0] r_pokemon_id;
  logic       r_frame_en;
  logic       r_sel_valid;
  logic [7:0] r_sel_id;
  logic [7:0] r_blink_cnt;
  logic [7:0] r_confirm_cnt;
  logic       w_move;

  // Ids are 1-based, so column/row come from id-1; left/right wrap within the row, up/down toggle it.
  function automatic logic [7:0] f_move(input logic [7:0] id, input logic l, input logic r);
    logic [7:0] col;
    logic       top;
    col = (id - 8'd1) % NC;
    top = (id <= NC);
    if (l)
      f_move = (col == 8'd0) ? (id + NC - 8'd1) : (id - 8'd1);
    else if (r)
      f_move = (col == NC - 8'd1) ? (id - (NC - 8'd1)) : (id + 8'd1);
    else
      f_move = top ? (id + NC) : (id - NC);
  endfunction

  assign w_move     = key_left | key_right | key_up | key_down;
  assign pokemon_id = r_pokemon_id;
  assign frame_en   = r_frame_en;
  assign sel_valid  = r_sel_valid;
  assign sel_id     = r_sel_id;
  assign state      = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pokemon_id  <= INIT8;
      r_frame_en    <= 1'b0;
      r_sel_valid   <= 1'b0;
      r_sel_id      <= 8'd0;
      r_blink_cnt   <= 8'd0;
      r_confirm_cnt <= 8'd0;
    end else if (!enable) begin
      r_state     <= S_IDLE;
      r_sel_valid <= 1'b0;
      r_frame_en  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pokemon_id <= INIT8;
          r_frame_en   <= 1'b1;
          r_blink_cnt  <= 8'd0;
          r_state      <= S_BROWSE;
        end
        S_BROWSE: begin
          if (key_enter) begin
            r_state       <= S_LOCKED;
            r_frame_en    <= 1'b1;
            r_confirm_cnt <= 8'd0;
          end else if (w_move && !key_back) begin
            r_pokemon_id <= f_move(r_pokemon_id, key_left, key_right);
            r_frame_en   <= 1'b1;
            r_blink_cnt  <= 8'd0;
          end else if (frame_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
              r_frame_en  <= ~r_frame_en;
              r_blink_cnt <= 8'd0;
            end else begin
              r_blink_cnt <= r_blink_cnt + 8'd1;
            end
          end
        end
        S_LOCKED: begin
          // back beats the final confirm tick
          if (key_back) begin
            r_state     <= S_BROWSE;
            r_blink_cnt <= 8'd0;
          end else if (frame_tick) begin
            if (r_confirm_cnt == CONF_LAST) begin
              r_sel_id    <= r_pokemon_id;
              r_sel_valid <= 1'b1;
              r_state     <= S_OFFER;
            end else begin
              r_confirm_cnt <= r_confirm_cnt + 8'd1;
            end
          end
        end
        S_OFFER: begin
          if (sel_ready) begin
            r_sel_valid <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE:  r_frame_en <= 1'b1;
        default: r_state    <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_choose_cursor_ctrl.sv
// Bench for choose_cursor_ctrl: directed scenarios plus randomized traffic against a grid-level model.
module tb_choose_cursor_ctrl;
  localparam int NC = 4, INIT = 1, BF = 15, CF = 30;
  localparam logic [8:0] EN = 9'h100, TK = 9'h080, KL = 9'h040, KR = 9'h020, KU = 9'h010,
                         KD = 9'h008, KE = 9'h004, KB = 9'h002, RDY = 9'h001;

  logic clk = 1'b0;
  logic rst_n;
  logic enable, frame_tick, key_left, key_right, key_up, key_down, key_enter, key_back, sel_ready;
  logic [7:0] pokemon_id, sel_id;
  logic frame_en, sel_valid;
  logic [2:0] state;
  logic [20:0] obs;

  int checks = 0, failures = 0;
  int m_state, m_id, m_fe, m_valid, m_sel, m_blink, m_conf;

  always #5 clk = ~clk;

  choose_cursor_ctrl #(.NUM_COLS(NC), .INIT_ID(INIT), .BLINK_FRAMES(BF), .CONFIRM_FRAMES(CF)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_tick(frame_tick),
    .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
    .key_enter(key_enter), .key_back(key_back), .sel_ready(sel_ready),
    .pokemon_id(pokemon_id), .frame_en(frame_en), .sel_valid(sel_valid), .sel_id(sel_id),
    .state(state)
  );

  assign obs = {state, pokemon_id, frame_en, sel_valid, sel_id};

  function automatic logic [20:0] exp_vec();
    return {m_state[2:0], m_id[7:0], m_fe[0], m_valid[0], m_sel[7:0]};
  endfunction

  task automatic model_reset();
    m_state = 0; m_id = INIT; m_fe = 0; m_valid = 0; m_sel = 0; m_blink = 0; m_conf = 0;
  endtask

  // Screen-level rules: grid position as (row, col), tick counters counted up to their frame totals.
  task automatic model_step(input logic [8:0] v);
    int col, row;
    logic en, tk, l, r, u, d, ent, bk, rdy;
    {en, tk, l, r, u, d, ent, bk, rdy} = v;
    if (!en) begin
      m_state = 0; m_valid = 0; m_fe = 0;
    end else begin
      case (m_state)
        0: begin m_id = INIT; m_fe = 1; m_blink = 0; m_state = 1; end
        1: begin
          if (ent) begin
            m_state = 2; m_fe = 1; m_conf = 0;
          end else if (!bk && (l || r || u || d)) begin
            col = (m_id - 1) % NC;
            row = (m_id - 1) / NC;
            if (l)      col = (col + NC - 1) % NC;
            else if (r) col = (col + 1) % NC;
            else        row = 1 - row;
            m_id = row * NC + col + 1;
            m_fe = 1; m_blink = 0;
          end else if (tk) begin
            m_blink++;
            if (m_blink == BF) begin m_fe = 1 - m_fe; m_blink = 0; end
          end
        end
        2: begin
          if (bk) begin
            m_state = 1; m_blink = 0;
          end else if (tk) begin
            m_conf++;
            if (m_conf == CF) begin m_sel = m_id; m_valid = 1; m_state = 3; end
          end
        end
        3: if (rdy) begin m_state = 4; m_valid = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic [8:0] v);
    @(negedge clk);
    {enable, frame_tick, key_left, key_right, key_up, key_down, key_enter, key_back, sel_ready} = v;
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {enable, frame_tick, key_left, key_right, key_up, key_down, key_enter, key_back, sel_ready} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== {3'd0, 8'd1, 1'b0, 1'b0, 8'd0}) begin
      failures++; $display("FAIL reset_values: got %h expected %h", obs, {3'd0, 8'd1, 1'b0, 1'b0, 8'd0});
    end
    @(negedge clk) rst_n = 1'b1;
    cyc('0);
    checks++;
    if (obs !== exp_vec()) begin
      failures++; $display("FAIL idle_hold: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_right_wrap();
    int ids[4] = '{2, 3, 4, 1};
    cyc(EN);
    checks++;
    if (state !== 3'd1 || pokemon_id !== 8'd1 || frame_en !== 1'b1) begin
      failures++; $display("FAIL browse_entry: got state=%0d id=%0d fe=%b expected 1 1 1", state, pokemon_id, frame_en);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(EN | KR);
      checks++;
      if (pokemon_id !== 8'(ids[i]) || frame_en !== 1'b1 || obs !== exp_vec()) begin
        failures++; $display("FAIL right_wrap[%0d]: got id=%0d fe=%b expected id=%0d fe=1", i, pokemon_id, frame_en, ids[i]);
      end
    end
  endtask

  task automatic test_moves();
    logic [8:0] seq[4] = '{EN | KL, EN | KU, EN | KD, EN | KU | KL};
    int ids[4] = '{8, 4, 8, 7};
    cyc(EN | KD);
    checks++;
    if (pokemon_id !== 8'd5) begin
      failures++; $display("FAIL move_to_5: got %0d expected 5", pokemon_id);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(seq[i]);
      checks++;
      if (pokemon_id !== 8'(ids[i]) || obs !== exp_vec()) begin
        failures++; $display("FAIL moves[%0d]: got id=%0d expected %0d", i, pokemon_id, ids[i]);
      end
    end
  endtask

  task automatic test_blink();
    for (int t = 1; t <= 45; t++) begin
      cyc(EN | TK);
      checks++;
      if (obs !== exp_vec() || (t % 15 == 0 && frame_en !== 1'(((t / 15) % 2) == 0))) begin
        failures++; $display("FAIL blink tick %0d: got %h expected %h", t, obs, exp_vec());
      end
      cyc(EN);
    end
    for (int t = 1; t <= 45; t++) begin
      cyc(t == 20 ? (EN | TK | KD) : (EN | TK));
      checks++;
      if (obs !== exp_vec() ||
          (t == 20 && (frame_en !== 1'b1 || pokemon_id !== 8'd3)) ||
          (t == 34 && frame_en !== 1'b1) || (t == 35 && frame_en !== 1'b0)) begin
        failures++; $display("FAIL blink_restart tick %0d: got %h expected %h", t, obs, exp_vec());
      end
    end
  endtask

  task automatic test_confirm_offer();
    logic [8:0] v;
    cyc('0); cyc(EN); cyc(EN | KR); cyc(EN | KD); cyc(EN | KE);
    checks++;
    if (state !== 3'd2 || pokemon_id !== 8'd6) begin
      failures++; $display("FAIL lock_at_6: got state=%0d id=%0d expected 2 6", state, pokemon_id);
    end
    for (int t = 1; t <= 30; t++) begin
      cyc(EN | TK);
      checks++;
      if (obs !== exp_vec() || (t == 29 && sel_valid !== 1'b0) ||
          (t == 30 && (state !== 3'd3 || sel_valid !== 1'b1 || sel_id !== 8'd6))) begin
        failures++; $display("FAIL confirm tick %0d: got %h expected %h", t, obs, exp_vec());
      end
      cyc(EN);
    end
    for (int i = 0; i < 10; i++) begin
      v = EN | (9'($urandom) & 9'h0FE);
      cyc(v);
      checks++;
      if (state !== 3'd3 || sel_valid !== 1'b1 || sel_id !== 8'd6 || obs !== exp_vec()) begin
        failures++; $display("FAIL offer_hold[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
    cyc(EN | RDY);
    checks++;
    if (state !== 3'd4 || sel_valid !== 1'b0 || obs !== exp_vec()) begin
      failures++; $display("FAIL handshake: got state=%0d valid=%b expected 4 0", state, sel_valid);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(EN | (9'($urandom) & 9'h0FF));
      checks++;
      if (state !== 3'd4 || pokemon_id !== 8'd6 || frame_en !== 1'b1) begin
        failures++; $display("FAIL done_frozen[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_lock_back_abort();
    cyc('0); cyc(EN); cyc(EN | KR); cyc(EN | KE);
    for (int t = 1; t <= 12; t++) cyc(t == 12 ? (EN | TK | KB) : (EN | TK));
    checks++;
    if (state !== 3'd1 || pokemon_id !== 8'd2 || sel_valid !== 1'b0 || obs !== exp_vec()) begin
      failures++; $display("FAIL lock_back: got state=%0d id=%0d valid=%b expected 1 2 0", state, pokemon_id, sel_valid);
    end
    cyc(EN | KE);
    for (int t = 1; t <= 30; t++) cyc(EN | TK);
    checks++;
    if (state !== 3'd3 || sel_id !== 8'd2) begin
      failures++; $display("FAIL reoffer: got state=%0d sel_id=%0d expected 3 2", state, sel_id);
    end
    cyc(RDY);
    checks++;
    if (state !== 3'd0 || sel_valid !== 1'b0 || obs !== exp_vec()) begin
      failures++; $display("FAIL abort_offer: got state=%0d valid=%b expected 0 0", state, sel_valid);
    end
    cyc(EN);
    checks++;
    if (state !== 3'd1 || pokemon_id !== 8'(INIT) || frame_en !== 1'b1) begin
      failures++; $display("FAIL reenter: got state=%0d id=%0d expected 1 %0d", state, pokemon_id, INIT);
    end
  endtask

  task automatic test_async_reset();
    cyc('0); cyc(EN); cyc(EN | KU); cyc(EN | KE);
    for (int t = 1; t <= 30; t++) cyc(EN | TK);
    checks++;
    if (state !== 3'd3 || sel_valid !== 1'b1 || sel_id !== 8'd5) begin
      failures++; $display("FAIL pre_reset_offer: got %h", obs);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== {3'd0, 8'd1, 1'b0, 1'b0, 8'd0}) begin
      failures++; $display("FAIL async_reset: got %h expected %h", obs, {3'd0, 8'd1, 1'b0, 1'b0, 8'd0});
    end
    model_reset();
    @(negedge clk);
    {enable, frame_tick, key_left, key_right, key_up, key_down, key_enter, key_back, sel_ready} = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [8:0] v;
    for (int i = 0; i < 3000; i++) begin
      v = 9'h000;
      if ($urandom_range(0, 199) != 0) v |= EN;
      if ($urandom_range(0, 1) == 0)   v |= TK;
      if ($urandom_range(0, 7) == 0)   v |= KL;
      if ($urandom_range(0, 7) == 0)   v |= KR;
      if ($urandom_range(0, 7) == 0)   v |= KU;
      if ($urandom_range(0, 7) == 0)   v |= KD;
      if ($urandom_range(0, 7) == 0)   v |= KE;
      if ($urandom_range(0, 63) == 0)  v |= KB;
      if ($urandom_range(0, 3) == 0)   v |= RDY;
      cyc(v);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL random[%0d] in=%h: got %h expected %h", i, v, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_right_wrap();
    test_moves();
    test_blink();
    test_confirm_offer();
    test_lock_back_abort();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
